// File: rtl/decode_top_if.sv
// Channel bundle between decode_top and its neighbours: fetch (f2d/d2f), execute (d2e)
// and the register file read ports. slave = decode side, master = environment side.
interface decode_top_if;
  logic         f2d_R;
  logic [63:0]  f2d;
  logic         f2d_A;
  logic         d2f_R;
  logic [32:0]  d2f;
  logic         d2f_A;
  logic         d2e_R;
  logic [108:0] d2e;
  logic         d2e_A;
  logic [4:0]   RF_RA1;
  logic [4:0]   RF_RA2;
  logic [31:0]  RF_RD1;
  logic [31:0]  RF_RD2;

  modport slave (
    input  f2d_R, f2d, d2f_R, d2e_A, RF_RD1, RF_RD2,
    output f2d_A, d2f, d2f_A, d2e_R, d2e, RF_RA1, RF_RA2
  );

  modport master (
    output f2d_R, f2d, d2f_R, d2e_A, RF_RD1, RF_RD2,
    input  f2d_A, d2f, d2f_A, d2e_R, d2e, RF_RA1, RF_RA2
  );
endinterface

// File: rtl/decode_top.sv
// MIPS decode stage: 4-phase f2d pull, RF read, branch/jump resolution, d2f answer, d2e push.
// Optional macro DECODE_ILLEGAL_TRAP_EN redirects unsupported instructions to EXC_VECTOR.
module decode_top (
  input logic          CLK,
  input logic          Z_R,
  decode_top_if.slave  bus
);
`ifdef DECODE_ILLEGAL_TRAP_EN
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180;
`endif

  typedef enum logic [2:0] {S_IDLE, S_AIN, S_RD, S_RES, S_FACK, S_EREQ, S_EREL} state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_ADDU = 4'd1, ALU_SUB = 4'd2, ALU_SUBU = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_PASS = 4'd11;

  state_t        r_state, w_state_next;
  logic [31:0]   r_instr, w_instr_next;
  logic [31:0]   r_pc4, w_pc4_next;
  logic          r_f2d_A, w_f2d_A_next;
  logic [32:0]   r_d2f, w_d2f_next;
  logic          r_d2f_A, w_d2f_A_next;
  logic          r_d2e_R, w_d2e_R_next;
  logic [108:0]  r_d2e, w_d2e_next;
  logic [4:0]    r_ra1, w_ra1_next;
  logic [4:0]    r_ra2, w_ra2_next;

  logic [5:0]    w_op, w_funct;
  logic [4:0]    w_rs, w_rt, w_rd, w_shamt;
  logic [31:0]   w_sext, w_zext, w_br_target, w_j_target;
  logic [3:0]    w_alu_op;
  logic          w_src, w_wr, w_mr, w_mw, w_redirect, w_legal;
  logic [31:0]   w_imm, w_target;
  logic [4:0]    w_dest;
  logic [32:0]   w_d2f_val;
  logic [108:0]  w_d2e_val;

  assign w_op        = r_instr[31:26];
  assign w_rs        = r_instr[25:21];
  assign w_rt        = r_instr[20:16];
  assign w_rd        = r_instr[15:11];
  assign w_shamt     = r_instr[10:6];
  assign w_funct     = r_instr[5:0];
  assign w_sext      = {{16{r_instr[15]}}, r_instr[15:0]};
  assign w_zext      = {16'b0, r_instr[15:0]};
  assign w_br_target = r_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {r_pc4[31:28], r_instr[25:0], 2'b00};

  // Decode uses the live RF read data; it is only captured in S_RES, after the settle cycle.
  always_comb begin
    w_alu_op   = ALU_ADD;
    w_src      = 1'b0;
    w_wr       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_imm      = 32'b0;
    w_dest     = w_rt;
    w_redirect = 1'b0;
    w_target   = 32'b0;
    w_legal    = 1'b1;
    case (w_op)
      6'h00: begin
        w_dest = w_rd;
        w_wr   = 1'b1;
        case (w_funct)
          6'h20: w_alu_op = ALU_ADD;
          6'h21: w_alu_op = ALU_ADDU;
          6'h22: w_alu_op = ALU_SUB;
          6'h23: w_alu_op = ALU_SUBU;
          6'h24: w_alu_op = ALU_AND;
          6'h25: w_alu_op = ALU_OR;
          6'h26: w_alu_op = ALU_XOR;
          6'h27: w_alu_op = ALU_NOR;
          6'h2A: w_alu_op = ALU_SLT;
          6'h00: begin w_alu_op = ALU_SLL; w_src = 1'b1; w_imm = {27'b0, w_shamt}; end
          6'h02: begin w_alu_op = ALU_SRL; w_src = 1'b1; w_imm = {27'b0, w_shamt}; end
          6'h08: begin w_wr = 1'b0; w_redirect = 1'b1; w_target = bus.RF_RD1; end
          default: w_legal = 1'b0;
        endcase
      end
      6'h08: begin w_alu_op = ALU_ADD;  w_src = 1'b1; w_wr = 1'b1; w_imm = w_sext; end
      6'h09: begin w_alu_op = ALU_ADDU; w_src = 1'b1; w_wr = 1'b1; w_imm = w_sext; end
      6'h0A: begin w_alu_op = ALU_SLT;  w_src = 1'b1; w_wr = 1'b1; w_imm = w_sext; end
      6'h0C: begin w_alu_op = ALU_AND;  w_src = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h0D: begin w_alu_op = ALU_OR;   w_src = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h0E: begin w_alu_op = ALU_XOR;  w_src = 1'b1; w_wr = 1'b1; w_imm = w_zext; end
      6'h0F: begin w_alu_op = ALU_PASS; w_src = 1'b1; w_wr = 1'b1; w_imm = {r_instr[15:0], 16'b0}; end
      6'h23: begin w_alu_op = ALU_ADD;  w_src = 1'b1; w_wr = 1'b1; w_mr = 1'b1; w_imm = w_sext; end
      6'h2B: begin w_alu_op = ALU_ADD;  w_src = 1'b1; w_mw = 1'b1; w_imm = w_sext; end
      6'h04: begin w_imm = w_sext; w_redirect = (bus.RF_RD1 == bus.RF_RD2); w_target = w_br_target; end
      6'h05: begin w_imm = w_sext; w_redirect = (bus.RF_RD1 != bus.RF_RD2); w_target = w_br_target; end
      6'h02: begin w_dest = 5'd0; w_redirect = 1'b1; w_target = w_j_target; end
      6'h03: begin
        w_alu_op = ALU_PASS; w_src = 1'b1; w_wr = 1'b1; w_imm = r_pc4; w_dest = 5'd31;
        w_redirect = 1'b1; w_target = w_j_target;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_d2e_val = w_legal ? {w_alu_op, w_src, w_wr, w_mr, w_mw, bus.RF_RD1, bus.RF_RD2, w_imm, w_dest}
                             : 109'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_d2f_val = !w_legal ? {1'b1, EXC_VECTOR} : (w_redirect ? {1'b1, w_target} : 33'b0);
`else
  assign w_d2f_val = (w_legal && w_redirect) ? {1'b1, w_target} : 33'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_instr_next = r_instr;
    w_pc4_next   = r_pc4;
    w_f2d_A_next = r_f2d_A;
    w_d2f_next   = r_d2f;
    w_d2f_A_next = r_d2f_A;
    w_d2e_R_next = r_d2e_R;
    w_d2e_next   = r_d2e;
    w_ra1_next   = r_ra1;
    w_ra2_next   = r_ra2;
    case (r_state)
      S_IDLE: if (bus.f2d_R) begin
        w_instr_next = bus.f2d[31:0];
        w_pc4_next   = bus.f2d[63:32];
        w_f2d_A_next = 1'b1;
        w_state_next = S_AIN;
      end
      S_AIN: if (!bus.f2d_R) begin
        w_f2d_A_next = 1'b0;
        w_ra1_next   = w_rs;
        w_ra2_next   = w_rt;
        w_state_next = S_RD;
      end
      S_RD: w_state_next = S_RES;
      S_RES: begin
        w_d2f_next   = w_d2f_val;
        w_d2e_next   = w_d2e_val;
        w_state_next = S_FACK;
      end
      S_FACK: begin
        if (!r_d2f_A && bus.d2f_R) begin
          w_d2f_A_next = 1'b1;
        end else if (r_d2f_A && !bus.d2f_R) begin
          w_d2f_A_next = 1'b0;
          w_d2f_next   = 33'b0;
          w_d2e_R_next = 1'b1;
          w_state_next = S_EREQ;
        end
      end
      S_EREQ: if (bus.d2e_A) begin
        w_d2e_R_next = 1'b0;
        w_state_next = S_EREL;
      end
      S_EREL: if (!bus.d2e_A) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Z_R) begin
      r_state <= S_IDLE;
      r_instr <= 32'b0;
      r_pc4   <= 32'b0;
      r_f2d_A <= 1'b0;
      r_d2f   <= 33'b0;
      r_d2f_A <= 1'b0;
      r_d2e_R <= 1'b0;
      r_d2e   <= 109'b0;
      r_ra1   <= 5'b0;
      r_ra2   <= 5'b0;
    end else begin
      r_state <= w_state_next;
      r_instr <= w_instr_next;
      r_pc4   <= w_pc4_next;
      r_f2d_A <= w_f2d_A_next;
      r_d2f   <= w_d2f_next;
      r_d2f_A <= w_d2f_A_next;
      r_d2e_R <= w_d2e_R_next;
      r_d2e   <= w_d2e_next;
      r_ra1   <= w_ra1_next;
      r_ra2   <= w_ra2_next;
    end
  end

  assign bus.f2d_A  = r_f2d_A;
  assign bus.d2f    = r_d2f;
  assign bus.d2f_A  = r_d2f_A;
  assign bus.d2e_R  = r_d2e_R;
  assign bus.d2e    = r_d2e;
  assign bus.RF_RA1 = r_ra1;
  assign bus.RF_RA2 = r_ra2;
endmodule

// File: tb/tb_decode_top.sv
// Directed bench for decode_top: plays fetch, execute and register file with zero-delay handshakes.
module tb_decode_top;
  logic clk = 1'b0;
  logic z_r = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [32:0]  cap_d2f;
  logic [108:0] cap_d2e;
  int           cap_lat;

  decode_top_if bus ();
  decode_top dut (.CLK(clk), .Z_R(z_r), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [108:0] obs, input logic [108:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.f2d_A;
      1: return bus.d2f_A;
      default: return bus.d2e_R;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string tag);
    int n = 0;
    while (sig(sel) !== val && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout %s observed=%b expected=%b", tag, sig(sel), val);
    end
  endtask

  task automatic xfer(input logic [31:0] pc4, input logic [31:0] ins,
                      input logic [31:0] rd1, input logic [31:0] rd2, input bit stop);
    int t0;
    bus.RF_RD1 = rd1;
    bus.RF_RD2 = rd2;
    bus.f2d    = {pc4, ins};
    bus.f2d_R  = 1'b1;
    t0 = cyc;
    wait_sig(0, 1'b1, "f2d_A_rise");
    bus.f2d_R = 1'b0;
    wait_sig(0, 1'b0, "f2d_A_fall");
    bus.d2f_R = 1'b1;
    wait_sig(1, 1'b1, "d2f_A_rise");
    cap_d2f = bus.d2f;
    bus.d2f_R = 1'b0;
    wait_sig(1, 1'b0, "d2f_A_fall");
    wait_sig(2, 1'b1, "d2e_R_rise");
    cap_lat = cyc - t0;
    cap_d2e = bus.d2e;
    if (stop) return;
    bus.d2e_A = 1'b1;
    wait_sig(2, 1'b0, "d2e_R_fall");
    bus.d2e_A = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] txn pc4=%h instr=%h d2f=%h d2e=%h lat=%0d", pc4, ins, cap_d2f, cap_d2e, cap_lat);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_f2d_A"}, 109'(bus.f2d_A), 109'd0);
    chk({tag, "_d2f_A"}, 109'(bus.d2f_A), 109'd0);
    chk({tag, "_d2e_R"}, 109'(bus.d2e_R), 109'd0);
    chk({tag, "_d2f"},   109'(bus.d2f),   109'd0);
    chk({tag, "_d2e"},   bus.d2e,         109'd0);
    chk({tag, "_ra"},    109'({bus.RF_RA1, bus.RF_RA2}), 109'd0);
  endtask

  initial begin
    bus.f2d_R = 1'b0; bus.f2d = 64'b0; bus.d2f_R = 1'b0; bus.d2e_A = 1'b0;
    bus.RF_RD1 = 32'b0; bus.RF_RD2 = 32'b0;

    // Reset held for two edges, then released idle.
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("reset");
    z_r = 1'b1;
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("post_release");

    // ADDI r8,r9,-1
    xfer(32'h0000_0004, 32'h2128_FFFF, 32'd5, 32'd0, 1'b0);
    chk("addi_d2f", 109'(cap_d2f), 109'd0);
    chk("addi_imm", 109'(cap_d2e[36:5]), 109'hFFFF_FFFF);
    chk("addi_dest", 109'(cap_d2e[4:0]), 109'd8);
    chk("addi_src_wr_mem", 109'(cap_d2e[104:101]), 109'b1100);
    chk("addi_rs_val", 109'(cap_d2e[100:69]), 109'd5);
    chk("addi_ra", 109'({bus.RF_RA1, bus.RF_RA2}), 109'({5'd9, 5'd8}));
    chk("addi_latency", 109'(cap_lat), 109'd6);
    chk("addi_d2f_cleared", 109'(bus.d2f), 109'd0);

    // BEQ r1,r2,+3 taken and not taken
    xfer(32'h0000_0100, 32'h1022_0003, 32'd7, 32'd7, 1'b0);
    chk("beq_taken_d2f", 109'(cap_d2f), 109'h1_0000_010C);
    chk("beq_ctrl", 109'(cap_d2e[108:101]), 109'd0);
    xfer(32'h0000_0100, 32'h1022_0003, 32'd7, 32'd8, 1'b0);
    chk("beq_nt_d2f", 109'(cap_d2f), 109'd0);

    // Branch target wraps modulo 2^32
    xfer(32'hFFFF_FFFC, 32'h1022_0001, 32'd3, 32'd3, 1'b0);
    chk("beq_wrap_d2f", 109'(cap_d2f), 109'h1_0000_0000);

    // JAL 0x40
    xfer(32'h8000_0004, 32'h0C00_0040, 32'd0, 32'd0, 1'b0);
    chk("jal_d2f", 109'(cap_d2f), 109'h1_8000_0100);
    chk("jal_dest", 109'(cap_d2e[4:0]), 109'd31);
    chk("jal_imm", 109'(cap_d2e[36:5]), 109'h8000_0004);
    chk("jal_wr", 109'(cap_d2e[103]), 109'd1);

    // JR r3
    xfer(32'h0000_0040, 32'h0060_0008, 32'h1234_5678, 32'd0, 1'b0);
    chk("jr_d2f", 109'(cap_d2f), 109'h1_1234_5678);
    chk("jr_ctrl", 109'(cap_d2e[108:101]), 109'd0);

    // LUI r5,0xABCD ; ORI r2,r1,0x8001 ; SLL r3,r4,7 ; SW r6,-8(r2)
    xfer(32'h0000_0010, 32'h3C05_ABCD, 32'd0, 32'd0, 1'b0);
    chk("lui_imm", 109'(cap_d2e[36:5]), 109'hABCD_0000);
    chk("lui_dest", 109'(cap_d2e[4:0]), 109'd5);
    xfer(32'h0000_0014, 32'h3422_8001, 32'd0, 32'd0, 1'b0);
    chk("ori_imm", 109'(cap_d2e[36:5]), 109'h0000_8001);
    xfer(32'h0000_0018, 32'h0004_19C0, 32'd0, 32'd9, 1'b0);
    chk("sll_imm_dest", 109'({cap_d2e[36:5], cap_d2e[4:0]}), 109'({32'd7, 5'd3}));
    chk("sll_rt_val", 109'(cap_d2e[68:37]), 109'd9);
    xfer(32'h0000_001C, 32'hAC46_FFF8, 32'd0, 32'd0, 1'b0);
    chk("sw_wr_mem", 109'(cap_d2e[103:101]), 109'b001);
    chk("sw_imm", 109'(cap_d2e[36:5]), 109'hFFFF_FFF8);

    // Unsupported opcode
    xfer(32'h0000_0020, 32'hFC00_0000, 32'd1, 32'd2, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("illegal_d2f", 109'(cap_d2f), 109'h1_0000_0180);
`else
    chk("illegal_d2f", 109'(cap_d2f), 109'd0);
`endif
    chk("illegal_d2e", cap_d2e, 109'd0);

    // Reset while d2e_R is held without ack, then resume normally
    xfer(32'h0000_0004, 32'h2128_FFFF, 32'd5, 32'd0, 1'b1);
    chk("pre_rst_d2e_R", 109'(bus.d2e_R), 109'd1);
    z_r = 1'b0;
    @(negedge clk);
    chk("mid_rst_d2e_R", 109'(bus.d2e_R), 109'd0);
    chk("mid_rst_d2e", bus.d2e, 109'd0);
    z_r = 1'b1;
    @(negedge clk);
    xfer(32'h0000_0104, 32'h2128_FFFF, 32'd11, 32'd0, 1'b0);
    chk("after_rst_rs_val", 109'(cap_d2e[100:69]), 109'd11);
    chk("after_rst_imm_dest", 109'({cap_d2e[36:5], cap_d2e[4:0]}), 109'({32'hFFFF_FFFF, 5'd8}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
